// File: rtl/somador_pkg.sv
// rtl/somador_pkg.sv - shared types and parameter helpers for the serial adder
package somador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_steps(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calc_cnt_w(input int width, input int digit);
        return $clog2(width / digit) + 1;
    endfunction

    function automatic bit params_ok(input int width, input int digit);
        return (digit > 0) && (width >= 2) && (width % digit == 0);
    endfunction

endpackage

// File: rtl/somador_digit.sv
// rtl/somador_digit.sv - combinational DIGIT-bit ripple adder slice
module somador_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co    = c[DIGIT];
    // carry into the slice's top bit; on the last step that is the word MSB
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/somador_serial.sv
// rtl/somador_serial.sv - multi-cycle adder reusing one DIGIT-bit slice per clock
module somador_serial
    import somador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CW    = calc_cnt_w(WIDTH, DIGIT);

    if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
        $error("somador_serial: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr, res_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] slice_s;
    logic             slice_co, slice_cmsb;
    logic             last, accept;

    somador_digit #(.DIGIT(DIGIT)) u_digit (
        .x     (a_sr[DIGIT-1:0]),
        .y     (b_sr[DIGIT-1:0]),
        .ci    (carry),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_cmsb)
    );

    // result fills from the top so the final step leaves it fully aligned
    if (DIGIT == WIDTH) begin : g_single
        assign res_nx = slice_s;
    end else begin : g_multi
        assign res_nx = {slice_s, r_sr[WIDTH-1:DIGIT]};
    end

    assign last = (cnt == CW'(STEPS - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    accept   = 1'b1;
                end
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nx = RUN;
                    accept   = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b;
                r_sr  <= '0;
                carry <= cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sr  <= a_sr >> DIGIT;
                b_sr  <= b_sr >> DIGIT;
                r_sr  <= res_nx;
                carry <= slice_co;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    sum      <= res_nx;
                    cout     <= slice_co;
                    overflow <= slice_cmsb ^ slice_co;
                end
            end
        end
    end

endmodule

// File: tb/tb_somador_serial.sv
// tb/tb_somador_serial.sv - directed and random checks of somador_serial for DIGIT 1, 2, 4, 8
module tb_somador_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic [3:0] busy_v, done_v, cout_v, ov_v;
    logic [7:0] sum_v [4];
    logic [7:0] hold  [4];

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        somador_serial #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .sum      (sum_v[g]),
            .cout     (cout_v[g]),
            .overflow (ov_v[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input logic [7:0] es, input logic ec, input logic eo, input string tag);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                int st;
                st = 8 >> g;
                check($sformatf("%s d%0d k%0d done", tag, 1 << g, k), done_v[g], k == st);
                check($sformatf("%s d%0d k%0d busy", tag, 1 << g, k), busy_v[g], k < st);
                if (k == st) begin
                    check($sformatf("%s d%0d sum", tag, 1 << g), sum_v[g], es);
                    check($sformatf("%s d%0d cout", tag, 1 << g), cout_v[g], ec);
                    check($sformatf("%s d%0d ovf", tag, 1 << g), ov_v[g], eo);
                    hold[g] = es;
                end else begin
                    check($sformatf("%s d%0d k%0d sum held", tag, 1 << g, k), sum_v[g], hold[g]);
                end
            end
        end
    endtask

    initial begin
        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[5] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        tbl[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("reset d%0d busy", 1 << g), busy_v[g], 0);
            check($sformatf("reset d%0d done", 1 << g), done_v[g], 0);
            check($sformatf("reset d%0d sum", 1 << g), sum_v[g], 0);
            check($sformatf("reset d%0d cout", 1 << g), cout_v[g], 0);
            check($sformatf("reset d%0d ovf", 1 << g), ov_v[g], 0);
            hold[g] = 8'h00;
        end
        rst = 1'b0;

        // start pulsed mid-run on the DIGIT=1 unit must be ignored
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 3) begin a = 8'h11; b = 8'h22; start = 1'b1; end
            if (k == 4) start = 1'b0;
            check($sformatf("midrun k%0d done", k), done_v[0], k == 8);
            check($sformatf("midrun k%0d busy", k), busy_v[0], k < 8);
            if (k == 8) check("midrun sum", sum_v[0], 8'h03);
        end
        repeat (10) @(negedge clk);
        hold[0] = 8'h03; hold[1] = 8'h03; hold[2] = 8'h33; hold[3] = 8'h33;

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].c, tbl[i].o,
                   $sformatf("vec%0d", i));

        // start held high: DIGIT=1 unit re-accepts every 9 cycles, on the done cycle
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("held k%0d done", k), done_v[0], (k == 8) || (k == 17));
            check($sformatf("held k%0d busy", k), busy_v[0], (k != 8) && (k != 17));
            if (k == 8 || k == 17) check($sformatf("held k%0d sum", k), sum_v[0], 8'h96);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        // reset in the middle of a DIGIT=1 run
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", busy_v[0], 0);
        check("midrst done", done_v[0], 0);
        check("midrst sum", sum_v[0], 0);
        check("midrst cout", cout_v[0], 0);
        check("midrst ovf", ov_v[0], 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("midrst k%0d no done", k), done_v, 4'b0000);
        end
        for (int g = 0; g < 4; g++) hold[g] = 8'h00;
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "afterrst");

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb, es;
            logic       rc, ec, eo;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            {ec, es} = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            eo = (ra[7] == rb[7]) && (es[7] != ra[7]);
            run_op(ra, rb, rc, es, ec, eo, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
